star_motion_sequencer: RTL and testbench

- Executes the 4-bit motion command word produced by the star hiding state machine.
- Generates step/dir pulses for the grill stepper and hide/show drive for the star actuator.
- Tracks grill position by step count and star position from limit switches, and feeds back the 2-bit position codes the state machine consumes.
- Enforces interlocks and a travel timeout; reports violations on o_fault.

---
 rtl/star_motion_sequencer.sv | 308 ++++++++++++++++++++++++++++++
 tb/tb_star_motion_sequencer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/star_motion_sequencer.sv
// star_motion_sequencer: runs the 4-bit motion command from the star hiding
// state machine. It steps the grill stepper, drives the star actuator, and
// reports grill/star position codes and a sticky fault flag.
//
// Ports:
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_cmd[3:0]              {step open, step close, act hide, act show}
//   i_star_up_sw            star fully shown limit switch (async)
//   i_star_hidden_sw        star fully hidden limit switch (async)
//   o_step, o_dir           stepper pulse and direction (1 = open)
//   o_act_hide, o_act_show  actuator drives
//   o_grill_pos[1:0]        00 closed, 01 open, 10 intermediate
//   o_star_pos[1:0]         00 shown, 01 hidden, 10 intermediate
//   o_fault                 sticky fault flag
module star_motion_sequencer #(
  parameter int unsigned STEP_DIV     = 1000,
  parameter int unsigned GRILL_STEPS  = 400,
  parameter int unsigned STAR_TIMEOUT = 50000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [3:0] i_cmd,
  input  logic       i_star_up_sw,
  input  logic       i_star_hidden_sw,
  output logic       o_step,
  output logic       o_dir,
  output logic       o_act_hide,
  output logic       o_act_show,
  output logic [1:0] o_grill_pos,
  output logic [1:0] o_star_pos,
  output logic       o_fault
);

  localparam int unsigned CNT_W = $clog2(GRILL_STEPS + 1);
  localparam int unsigned DIV_W = $clog2(2 * STEP_DIV);
  localparam int unsigned TMO_W = $clog2(STAR_TIMEOUT + 1);

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(GRILL_STEPS);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(2 * STEP_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HIGH = DIV_W'(STEP_DIV);
  localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(STAR_TIMEOUT);

  localparam logic [3:0] CMD_NONE  = 4'b0000;
  localparam logic [3:0] CMD_OPEN  = 4'b1000;
  localparam logic [3:0] CMD_CLOSE = 4'b0100;
  localparam logic [3:0] CMD_HIDE  = 4'b0010;
  localparam logic [3:0] CMD_SHOW  = 4'b0001;

  localparam logic [1:0] GRILL_CLOSED = 2'b00;
  localparam logic [1:0] GRILL_OPEN   = 2'b01;
  localparam logic [1:0] STAR_SHOWN   = 2'b00;
  localparam logic [1:0] STAR_HIDDEN  = 2'b01;
  localparam logic [1:0] POS_MID      = 2'b10;

  typedef enum logic [1:0] {
    STP_IDLE  = 2'd0,
    STP_OPEN  = 2'd1,
    STP_CLOSE = 2'd2
  } stp_state_e;

  typedef enum logic [1:0] {
    ACT_IDLE    = 2'd0,
    ACT_HIDE    = 2'd1,
    ACT_SHOW    = 2'd2,
    ACT_TIMEOUT = 2'd3
  } act_state_e;

  logic [3:0]       cmd_q, cmd_d;
  logic             up_meta_q, up_meta_d, up_sync_q, up_sync_d;
  logic             hid_meta_q, hid_meta_d, hid_sync_q, hid_sync_d;
  logic [1:0]       star_pos_q, star_pos_d;
  logic [1:0]       grill_pos_q, grill_pos_d;
  stp_state_e       stp_state_q, stp_state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             step_q, step_d;
  logic             dir_q, dir_d;
  act_state_e       act_state_q, act_state_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             act_hide_q, act_hide_d;
  logic             act_show_q, act_show_d;
  logic             fault_q, fault_d;

  logic             sw_conflict_c;
  logic             tmo_event_c;
  logic             interlock_c;
  logic             stp_req_c, act_req_c;

  // Switch synchronizers, command register and position encoding
  always_comb begin
    cmd_d         = i_cmd;
    up_meta_d     = i_star_up_sw;
    up_sync_d     = up_meta_q;
    hid_meta_d    = i_star_hidden_sw;
    hid_sync_d    = hid_meta_q;
    sw_conflict_c = up_sync_q & hid_sync_q;

    unique case ({up_sync_q, hid_sync_q})
      2'b10:   star_pos_d = STAR_SHOWN;
      2'b01:   star_pos_d = STAR_HIDDEN;
      default: star_pos_d = POS_MID;
    endcase

    if (count_q == '0) begin
      grill_pos_d = GRILL_CLOSED;
    end else if (count_q == CNT_MAX) begin
      grill_pos_d = GRILL_OPEN;
    end else begin
      grill_pos_d = POS_MID;
    end
  end

  // Stepper FSM: one step = STEP_DIV high clocks then STEP_DIV low clocks
  always_comb begin
    stp_state_d = stp_state_q;
    div_d       = div_q;
    count_d     = count_q;
    step_d      = 1'b0;
    dir_d       = dir_q;

    unique case (stp_state_q)
      STP_IDLE: begin
        div_d = '0;
        if (act_state_q == ACT_IDLE && star_pos_q != POS_MID) begin
          if (cmd_q == CMD_OPEN && count_q != CNT_MAX) begin
            stp_state_d = STP_OPEN;
            dir_d       = 1'b1;
            step_d      = 1'b1;
          end else if (cmd_q == CMD_CLOSE && count_q != '0) begin
            stp_state_d = STP_CLOSE;
            dir_d       = 1'b0;
            step_d      = 1'b1;
          end
        end
      end

      STP_OPEN, STP_CLOSE: begin
        if (cmd_q != ((stp_state_q == STP_OPEN) ? CMD_OPEN : CMD_CLOSE)) begin
          // Command withdrawn: abandon the partial step uncounted
          stp_state_d = STP_IDLE;
          div_d       = '0;
        end else if (div_q == DIV_LAST) begin
          // End of low phase: the step is complete
          div_d = '0;
          if (stp_state_q == STP_OPEN) begin
            if (count_q != CNT_MAX) begin
              count_d = count_q + CNT_W'(1);
            end
            if (count_d == CNT_MAX) begin
              stp_state_d = STP_IDLE;
            end else begin
              step_d = 1'b1;
            end
          end else begin
            if (count_q != '0) begin
              count_d = count_q - CNT_W'(1);
            end
            if (count_d == '0) begin
              stp_state_d = STP_IDLE;
            end else begin
              step_d = 1'b1;
            end
          end
        end else begin
          div_d  = div_q + DIV_W'(1);
          step_d = (div_d < DIV_HIGH);
        end
      end

      default: begin
        stp_state_d = STP_IDLE;
        div_d       = '0;
      end
    endcase
  end

  // Actuator FSM with travel timeout; tmo counts drive clocks issued so far
  always_comb begin
    act_state_d = act_state_q;
    tmo_d       = tmo_q;
    act_hide_d  = 1'b0;
    act_show_d  = 1'b0;
    tmo_event_c = 1'b0;

    unique case (act_state_q)
      ACT_IDLE: begin
        tmo_d = '0;
        if (stp_state_q == STP_IDLE && count_q == CNT_MAX && !sw_conflict_c) begin
          if (cmd_q == CMD_HIDE && star_pos_q != STAR_HIDDEN) begin
            act_state_d = ACT_HIDE;
            act_hide_d  = 1'b1;
            tmo_d       = TMO_W'(1);
          end else if (cmd_q == CMD_SHOW && star_pos_q != STAR_SHOWN) begin
            act_state_d = ACT_SHOW;
            act_show_d  = 1'b1;
            tmo_d       = TMO_W'(1);
          end
        end
      end

      ACT_HIDE: begin
        if (cmd_q != CMD_HIDE || hid_sync_q) begin
          act_state_d = ACT_IDLE;
          tmo_d       = '0;
        end else if (tmo_q == TMO_MAX) begin
          act_state_d = ACT_TIMEOUT;
          tmo_event_c = 1'b1;
        end else begin
          tmo_d      = tmo_q + TMO_W'(1);
          act_hide_d = 1'b1;
        end
      end

      ACT_SHOW: begin
        if (cmd_q != CMD_SHOW || up_sync_q) begin
          act_state_d = ACT_IDLE;
          tmo_d       = '0;
        end else if (tmo_q == TMO_MAX) begin
          act_state_d = ACT_TIMEOUT;
          tmo_event_c = 1'b1;
        end else begin
          tmo_d      = tmo_q + TMO_W'(1);
          act_show_d = 1'b1;
        end
      end

      ACT_TIMEOUT: begin
        tmo_d = '0;
        if (cmd_q == CMD_NONE) begin
          act_state_d = ACT_IDLE;
        end
      end

      default: begin
        act_state_d = ACT_IDLE;
        tmo_d       = '0;
      end
    endcase
  end

  // Interlocks and sticky fault; setting wins over clearing
  always_comb begin
    stp_req_c   = |cmd_q[3:2];
    act_req_c   = |cmd_q[1:0];
    interlock_c = (cmd_q[3] & cmd_q[2])
                | (cmd_q[1] & cmd_q[0])
                | (stp_req_c & act_req_c)
                | (act_req_c & (count_q != CNT_MAX))
                | (stp_req_c & (star_pos_q == POS_MID));

    fault_d = fault_q;
    if (interlock_c || sw_conflict_c || tmo_event_c) begin
      fault_d = 1'b1;
    end else if (cmd_q == CMD_NONE) begin
      fault_d = 1'b0;
    end
  end

  // State registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cmd_q       <= CMD_NONE;
      up_meta_q   <= 1'b0;
      up_sync_q   <= 1'b0;
      hid_meta_q  <= 1'b0;
      hid_sync_q  <= 1'b0;
      star_pos_q  <= POS_MID;
      grill_pos_q <= GRILL_CLOSED;
      stp_state_q <= STP_IDLE;
      div_q       <= '0;
      count_q     <= '0;
      step_q      <= 1'b0;
      dir_q       <= 1'b0;
      act_state_q <= ACT_IDLE;
      tmo_q       <= '0;
      act_hide_q  <= 1'b0;
      act_show_q  <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      cmd_q       <= cmd_d;
      up_meta_q   <= up_meta_d;
      up_sync_q   <= up_sync_d;
      hid_meta_q  <= hid_meta_d;
      hid_sync_q  <= hid_sync_d;
      star_pos_q  <= star_pos_d;
      grill_pos_q <= grill_pos_d;
      stp_state_q <= stp_state_d;
      div_q       <= div_d;
      count_q     <= count_d;
      step_q      <= step_d;
      dir_q       <= dir_d;
      act_state_q <= act_state_d;
      tmo_q       <= tmo_d;
      act_hide_q  <= act_hide_d;
      act_show_q  <= act_show_d;
      fault_q     <= fault_d;
    end
  end

  assign o_step      = step_q;
  assign o_dir       = dir_q;
  assign o_act_hide  = act_hide_q;
  assign o_act_show  = act_show_q;
  assign o_grill_pos = grill_pos_q;
  assign o_star_pos  = star_pos_q;
  assign o_fault     = fault_q;

endmodule

// File: tb/tb_star_motion_sequencer.sv
// Directed bench for star_motion_sequencer with small parameters.
module tb_star_motion_sequencer;

  logic       clk;
  logic       rst_n;
  logic [3:0] cmd;
  logic       up_sw;
  logic       hid_sw;
  logic       step;
  logic       dir;
  logic       act_hide;
  logic       act_show;
  logic [1:0] grill_pos;
  logic [1:0] star_pos;
  logic       fault;

  int n_checks;
  int n_errors;
  int rises;
  logic prev_step;

  star_motion_sequencer #(
    .STEP_DIV    (2),
    .GRILL_STEPS (4),
    .STAR_TIMEOUT(20)
  ) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_cmd           (cmd),
    .i_star_up_sw    (up_sw),
    .i_star_hidden_sw(hid_sw),
    .o_step          (step),
    .o_dir           (dir),
    .o_act_hide      (act_hide),
    .o_act_show      (act_show),
    .o_grill_pos     (grill_pos),
    .o_star_pos      (star_pos),
    .o_fault         (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    cmd      = 4'b0000;
    up_sw    = 1'b1;
    hid_sw   = 1'b0;
    #12;
    check_eq("rst_step", 32'(step), 32'd0);
    check_eq("rst_dir", 32'(dir), 32'd0);
    check_eq("rst_hide", 32'(act_hide), 32'd0);
    check_eq("rst_show", 32'(act_show), 32'd0);
    check_eq("rst_gpos", 32'(grill_pos), 32'd0);
    check_eq("rst_spos", 32'(star_pos), 32'd2);
    check_eq("rst_fault", 32'(fault), 32'd0);
    #4 rst_n = 1'b1;
    tick(4);
    check_eq("sync_spos", 32'(star_pos), 32'd0);

    // Full open: 4 steps, 2 high / 2 low
    cmd = 4'b1000;
    tick(1);
    check_eq("open_lat", 32'(step), 32'd0);
    tick(1);
    for (int i = 1; i <= 20; i++) begin
      check_eq("open_step", 32'(step), ((i <= 16) && (((i - 1) % 4) < 2)) ? 32'd1 : 32'd0);
      check_eq("open_gpos", 32'(grill_pos), (i <= 5) ? 32'd0 : ((i <= 17) ? 32'd2 : 32'd1));
      check_eq("open_dir", 32'(dir), 32'd1);
      tick(1);
    end
    check_eq("open_noop_step", 32'(step), 32'd0);
    check_eq("open_noop_fault", 32'(fault), 32'd0);

    // Hide with hidden switch arriving 10 clocks later
    cmd   = 4'b0010;
    up_sw = 1'b0;
    tick(1);
    check_eq("hide_lat", 32'(act_hide), 32'd0);
    tick(1);
    for (int i = 1; i <= 12; i++) begin
      check_eq("hide_on", 32'(act_hide), 32'd1);
      if (i == 1) check_eq("hide_spos0", 32'(star_pos), 32'd0);
      if (i == 2) check_eq("hide_spos_mid", 32'(star_pos), 32'd2);
      if (i == 10) hid_sw = 1'b1;
      tick(1);
    end
    check_eq("hide_off", 32'(act_hide), 32'd0);
    check_eq("hide_spos", 32'(star_pos), 32'd1);
    check_eq("hide_fault", 32'(fault), 32'd0);

    // Show briefly, then withdraw the command
    cmd = 4'b0001;
    tick(2);
    check_eq("show_on", 32'(act_show), 32'd1);
    check_eq("show_nohide", 32'(act_hide), 32'd0);
    cmd = 4'b0000;
    tick(2);
    check_eq("show_drop", 32'(act_show), 32'd0);

    // Hide timeout with no switch
    hid_sw = 1'b0;
    tick(4);
    check_eq("tmo_spos", 32'(star_pos), 32'd2);
    check_eq("tmo_fault0", 32'(fault), 32'd0);
    cmd = 4'b0010;
    tick(1);
    check_eq("tmo_lat", 32'(act_hide), 32'd0);
    for (int i = 1; i <= 25; i++) begin
      tick(1);
      check_eq("tmo_hide", 32'(act_hide), (i <= 20) ? 32'd1 : 32'd0);
      check_eq("tmo_fault", 32'(fault), (i >= 21) ? 32'd1 : 32'd0);
    end
    cmd = 4'b0000;
    tick(1);
    check_eq("tmo_hold", 32'(fault), 32'd1);
    tick(1);
    check_eq("tmo_clear", 32'(fault), 32'd0);
    cmd = 4'b0010;
    tick(2);
    check_eq("tmo_rearm", 32'(act_hide), 32'd1);
    cmd = 4'b0000;
    tick(1);
    check_eq("drop_hold", 32'(act_hide), 32'd1);
    tick(1);
    check_eq("drop_off", 32'(act_hide), 32'd0);

    // Stepper command while star intermediate
    cmd = 4'b0100;
    tick(2);
    check_eq("mid_fault", 32'(fault), 32'd1);
    check_eq("mid_nostep", 32'(step), 32'd0);
    cmd   = 4'b0000;
    up_sw = 1'b1;
    tick(4);
    check_eq("mid_clear", 32'(fault), 32'd0);
    check_eq("mid_spos", 32'(star_pos), 32'd0);

    // Full close
    cmd = 4'b0100;
    tick(2);
    check_eq("close_step", 32'(step), 32'd1);
    check_eq("close_dir", 32'(dir), 32'd0);
    tick(20);
    check_eq("close_gpos", 32'(grill_pos), 32'd0);
    check_eq("close_idle", 32'(step), 32'd0);
    check_eq("close_fault", 32'(fault), 32'd0);

    // Interlocks on a closed grill
    cmd = 4'b0010;
    tick(2);
    check_eq("il_hide_closed_f", 32'(fault), 32'd1);
    check_eq("il_hide_closed_d", 32'(act_hide), 32'd0);
    cmd = 4'b0000;
    tick(2);
    check_eq("il_clear1", 32'(fault), 32'd0);
    cmd = 4'b1100;
    tick(2);
    check_eq("il_both_f", 32'(fault), 32'd1);
    check_eq("il_both_s", 32'(step), 32'd0);
    cmd = 4'b0000;
    tick(2);
    check_eq("il_clear2", 32'(fault), 32'd0);
    cmd = 4'b1010;
    tick(2);
    check_eq("il_mix_f", 32'(fault), 32'd1);
    check_eq("il_mix_s", 32'(step), 32'd0);
    cmd = 4'b0000;
    tick(2);

    // Both limit switches set
    hid_sw = 1'b1;
    tick(4);
    check_eq("conf_spos", 32'(star_pos), 32'd2);
    check_eq("conf_fault", 32'(fault), 32'd1);
    hid_sw = 1'b0;
    tick(4);
    check_eq("conf_clear", 32'(fault), 32'd0);
    check_eq("conf_spos2", 32'(star_pos), 32'd0);

    // Open interrupted during 3rd step's high phase
    cmd = 4'b1000;
    tick(10);
    check_eq("part_high", 32'(step), 32'd1);
    cmd = 4'b0000;
    tick(1);
    check_eq("part_hold", 32'(step), 32'd1);
    tick(1);
    check_eq("part_low", 32'(step), 32'd0);
    tick(1);
    check_eq("part_gpos", 32'(grill_pos), 32'd2);
    cmd       = 4'b0100;
    rises     = 0;
    prev_step = step;
    for (int i = 0; i < 30; i++) begin
      tick(1);
      if (step && !prev_step) rises++;
      prev_step = step;
    end
    check_eq("part_close_steps", 32'(rises), 32'd2);
    check_eq("part_close_gpos", 32'(grill_pos), 32'd0);

    // Reset in the middle of a step
    cmd = 4'b1000;
    tick(7);
    check_eq("mrst_pre_step", 32'(step), 32'd1);
    check_eq("mrst_pre_gpos", 32'(grill_pos), 32'd2);
    cmd = 4'b0000;
    #2 rst_n = 1'b0;
    #1;
    check_eq("mrst_step", 32'(step), 32'd0);
    check_eq("mrst_hide", 32'(act_hide), 32'd0);
    check_eq("mrst_show", 32'(act_show), 32'd0);
    check_eq("mrst_spos", 32'(star_pos), 32'd2);
    #2 rst_n = 1'b1;
    tick(4);
    check_eq("mrst_gpos", 32'(grill_pos), 32'd0);
    check_eq("mrst_spos2", 32'(star_pos), 32'd0);
    cmd = 4'b0100;
    tick(3);
    check_eq("mrst_noclose", 32'(step), 32'd0);
    check_eq("mrst_nofault", 32'(fault), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
